// File: rtl/dp_sequencer_if.sv
// dp_sequencer_if: instruction handshake plus datapath control/result bus.
//   slave  : sequencer side (accepts instructions, drives datapath controls)
//   master : upstream/datapath side (drives instructions, returns ALU result/flags)
interface dp_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic              dp_wen;
  logic [ADDR_W-1:0] dp_waddr;
  logic [DATA_W-1:0] dp_wdata;
  logic [ADDR_W-1:0] dp_raddr1;
  logic [ADDR_W-1:0] dp_raddr2;
  logic [2:0]        dp_alu_ctrl;
  logic [DATA_W-1:0] dp_alu_result;
  logic              dp_zero;
  logic              dp_carry;
  logic              dp_overflow;

  modport slave (
    input  instr_valid, instr, dp_alu_result, dp_zero, dp_carry, dp_overflow,
    output instr_ready, dp_wen, dp_waddr, dp_wdata, dp_raddr1, dp_raddr2, dp_alu_ctrl
  );

  modport master (
    output instr_valid, instr, dp_alu_result, dp_zero, dp_carry, dp_overflow,
    input  instr_ready, dp_wen, dp_waddr, dp_wdata, dp_raddr1, dp_raddr2, dp_alu_ctrl
  );
endinterface

// File: rtl/dp_sequencer.sv
// dp_sequencer: single-issue, non-pipelined instruction sequencer for datapath_top.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : instruction valid/ready/instr and all datapath controls/results
//   flags_q      : sticky {overflow, carry, zero} captured at EXEC exit
//   halted       : HALT executed (cleared only by rst)
//   retired_cnt  : wrapping count of retired instructions
//   illegal_q    : sticky illegal-ALU-op trap (only with DP_SEQ_ILLEGAL_TRAP_EN)
// Optional feature macro: DP_SEQ_ILLEGAL_TRAP_EN (traps alu_op 3'b110/3'b111).
module dp_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  dp_sequencer_if.slave    bus,
  output logic [2:0]       flags_q,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt
`ifdef DP_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic             illegal_q
`endif
);

  localparam logic [1:0] CLS_LDI  = 2'b00;
  localparam logic [1:0] CLS_ALU  = 2'b01;
  localparam logic [1:0] CLS_NOP  = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB, ST_HALT} state_e;

  state_e            state_q;
  logic              ready_q;
  logic              wen_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] raddr1_q;
  logic [ADDR_W-1:0] raddr2_q;
  logic [2:0]        alu_ctrl_q;
  logic [ADDR_W-1:0] rd_q;
  logic              cmp_q;
  logic              halted_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic [1:0]        cls;
  logic              unused_bits;

  assign accept      = bus.instr_valid & ready_q;
  assign cls         = bus.instr[15:14];
  assign unused_bits = bus.instr[0];

  // Main FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      raddr1_q   <= '0;
      raddr2_q   <= '0;
      alu_ctrl_q <= '0;
      rd_q       <= '0;
      cmp_q      <= 1'b0;
      flags_q    <= '0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
`ifdef DP_SEQ_ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            case (cls)
              CLS_LDI: begin
                waddr_q <= ADDR_W'(bus.instr[10:8]);
                wdata_q <= DATA_W'(bus.instr[7:0]);
                wen_q   <= 1'b1;
                cmp_q   <= 1'b0;  // WB must count the LDI
                ready_q <= 1'b0;
                state_q <= ST_WB;
              end
              CLS_ALU: begin
`ifdef DP_SEQ_ILLEGAL_TRAP_EN
                if (bus.instr[13:12] == 2'b11) begin
                  // Trap and drop: stay ready in IDLE, nothing retires.
                  illegal_q <= 1'b1;
                end else
`endif
                begin
                  raddr1_q   <= ADDR_W'(bus.instr[7:5]);
                  raddr2_q   <= ADDR_W'(bus.instr[4:2]);
                  alu_ctrl_q <= bus.instr[13:11];
                  rd_q       <= ADDR_W'(bus.instr[10:8]);
                  cmp_q      <= bus.instr[1];
                  ready_q    <= 1'b0;
                  state_q    <= ST_EXEC;
                end
              end
              CLS_NOP: begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
              default: begin
                halted_q <= 1'b1;
                cnt_q    <= cnt_q + CNT_W'(1);
                ready_q  <= 1'b0;
                state_q  <= ST_HALT;
              end
            endcase
          end
        end
        ST_EXEC: begin
          flags_q <= {bus.dp_overflow, bus.dp_carry, bus.dp_zero};
          if (cmp_q) begin
            cnt_q <= cnt_q + CNT_W'(1);  // CMP retires here; WB skips the count
          end else begin
            wdata_q <= bus.dp_alu_result;
            waddr_q <= rd_q;
            wen_q   <= 1'b1;
          end
          state_q <= ST_WB;
        end
        ST_WB: begin
          wen_q <= 1'b0;
          if (!cmp_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.dp_wen      = wen_q;
  assign bus.dp_waddr    = waddr_q;
  assign bus.dp_wdata    = wdata_q;
  assign bus.dp_raddr1   = raddr1_q;
  assign bus.dp_raddr2   = raddr2_q;
  assign bus.dp_alu_ctrl = alu_ctrl_q;
  assign halted          = halted_q;
  assign retired_cnt     = cnt_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed testbench for dp_sequencer with a small register-file/ALU datapath stub.
module tb_dp_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] flags_q;
  logic       halted;
  logic [7:0] retired_cnt;
`ifdef DP_SEQ_ILLEGAL_TRAP_EN
  logic       illegal_q;
`endif

  int n_cmp;
  int n_err;

  dp_sequencer_if bus ();

  dp_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flags_q     (flags_q),
    .halted      (halted),
    .retired_cnt (retired_cnt)
`ifdef DP_SEQ_ILLEGAL_TRAP_EN
    ,
    .illegal_q   (illegal_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stub: 8x8 register file (shares rst) and a combinational ALU.
  logic [7:0] rf [8];
  logic [7:0] opa, opb, res;
  logic       c_out, v_out;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (bus.dp_wen) begin
      rf[bus.dp_waddr] <= bus.dp_wdata;
    end
  end

  always_comb begin
    opa   = rf[bus.dp_raddr1];
    opb   = rf[bus.dp_raddr2];
    res   = 8'h00;
    c_out = 1'b0;
    v_out = 1'b0;
    case (bus.dp_alu_ctrl)
      3'b000: begin
        {c_out, res} = {1'b0, opa} + {1'b0, opb};
        v_out = (opa[7] == opb[7]) && (res[7] != opa[7]);
      end
      3'b001: begin
        res   = opa - opb;
        c_out = (opa < opb);
        v_out = (opa[7] != opb[7]) && (res[7] != opa[7]);
      end
      3'b010: res = opa & opb;
      3'b011: res = opa | opb;
      3'b100: res = opa ^ opb;
      default: res = 8'h00;
    endcase
  end

  assign bus.dp_alu_result = res;
  assign bus.dp_zero       = (res == 8'h00);
  assign bus.dp_carry      = c_out;
  assign bus.dp_overflow   = v_out;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until accepted (bounded wait).
  task automatic issue(input logic [15:0] word);
    int guard;
    guard = 0;
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    while (bus.instr_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    n_cmp++;
    if (guard >= 20) begin
      n_err++;
      $display("FAIL issue_timeout: instr_ready=%b required 1", bus.instr_ready);
    end
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    step();
    step();
    n_cmp++;
    if ({bus.instr_ready, bus.dp_wen, bus.dp_waddr, bus.dp_wdata, bus.dp_raddr1,
         bus.dp_raddr2, bus.dp_alu_ctrl, flags_q, halted, retired_cnt} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b wen=%b flags=%b halted=%b cnt=%0d required all 0",
               bus.instr_ready, bus.dp_wen, flags_q, halted, retired_cnt);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (bus.instr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: ready=%b required 1", bus.instr_ready);
    end
  endtask

  task automatic test_ldi();
    issue(16'h010A);  // LDI R1, 0x0A
    n_cmp++;
    if ({bus.instr_ready, bus.dp_wen, bus.dp_waddr, bus.dp_wdata} !== {1'b0, 1'b1, 3'd1, 8'h0A}) begin
      n_err++;
      $display("FAIL ldi1_wb: ready=%b wen=%b waddr=%0d wdata=%h required 0 1 1 0a",
               bus.instr_ready, bus.dp_wen, bus.dp_waddr, bus.dp_wdata);
    end
    step();
    n_cmp++;
    if ({bus.dp_wen, bus.instr_ready, retired_cnt, rf[1]} !== {1'b0, 1'b1, 8'd1, 8'h0A}) begin
      n_err++;
      $display("FAIL ldi1_done: wen=%b ready=%b cnt=%0d r1=%h required 0 1 1 0a",
               bus.dp_wen, bus.instr_ready, retired_cnt, rf[1]);
    end
    issue(16'h0205);  // LDI R2, 0x05
    n_cmp++;
    if ({bus.dp_wen, bus.dp_waddr, bus.dp_wdata} !== {1'b1, 3'd2, 8'h05}) begin
      n_err++;
      $display("FAIL ldi2_wb: wen=%b waddr=%0d wdata=%h required 1 2 05",
               bus.dp_wen, bus.dp_waddr, bus.dp_wdata);
    end
    step();
    n_cmp++;
    if ({bus.dp_wen, retired_cnt, rf[2]} !== {1'b0, 8'd2, 8'h05}) begin
      n_err++;
      $display("FAIL ldi2_done: wen=%b cnt=%0d r2=%h required 0 2 05", bus.dp_wen, retired_cnt, rf[2]);
    end
  endtask

  task automatic test_alu_add();
    issue(16'h4328);  // ADD R3 = R1 + R2
    n_cmp++;
    if ({bus.instr_ready, bus.dp_wen, bus.dp_raddr1, bus.dp_raddr2, bus.dp_alu_ctrl} !==
        {1'b0, 1'b0, 3'd1, 3'd2, 3'd0}) begin
      n_err++;
      $display("FAIL add_exec: ready=%b wen=%b ra1=%0d ra2=%0d ctrl=%0d required 0 0 1 2 0",
               bus.instr_ready, bus.dp_wen, bus.dp_raddr1, bus.dp_raddr2, bus.dp_alu_ctrl);
    end
    step();
    n_cmp++;
    if ({bus.instr_ready, bus.dp_wen, bus.dp_waddr, bus.dp_wdata, flags_q} !==
        {1'b0, 1'b1, 3'd3, 8'h0F, 3'b000}) begin
      n_err++;
      $display("FAIL add_wb: ready=%b wen=%b waddr=%0d wdata=%h flags=%b required 0 1 3 0f 000",
               bus.instr_ready, bus.dp_wen, bus.dp_waddr, bus.dp_wdata, flags_q);
    end
    step();
    n_cmp++;
    if ({bus.instr_ready, bus.dp_wen, retired_cnt, rf[3]} !== {1'b1, 1'b0, 8'd3, 8'h0F}) begin
      n_err++;
      $display("FAIL add_done: ready=%b wen=%b cnt=%0d r3=%h required 1 0 3 0f",
               bus.instr_ready, bus.dp_wen, retired_cnt, rf[3]);
    end
  endtask

  task automatic test_cmp();
    logic saw_wen;
    issue(16'h4C4A);  // SUB R2 - R2, CMP, rd=4
    saw_wen = bus.dp_wen;
    step();
    saw_wen |= bus.dp_wen;
    n_cmp++;
    if ({flags_q, retired_cnt} !== {3'b001, 8'd4}) begin
      n_err++;
      $display("FAIL cmp_flags: flags=%b cnt=%0d required 001 4", flags_q, retired_cnt);
    end
    step();
    saw_wen |= bus.dp_wen;
    n_cmp++;
    if ({saw_wen, bus.instr_ready, retired_cnt, rf[4]} !== {1'b0, 1'b1, 8'd4, 8'h00}) begin
      n_err++;
      $display("FAIL cmp_nowrite: saw_wen=%b ready=%b cnt=%0d r4=%h required 0 1 4 00",
               saw_wen, bus.instr_ready, retired_cnt, rf[4]);
    end
    issue(16'h0500);  // LDI R5, 0 must not touch flags
    step();
    n_cmp++;
    if ({flags_q, retired_cnt} !== {3'b001, 8'd5}) begin
      n_err++;
      $display("FAIL ldi_keeps_flags: flags=%b cnt=%0d required 001 5", flags_q, retired_cnt);
    end
  endtask

  task automatic test_same_reg();
    issue(16'h4124);  // ADD R1 = R1 + R1
    step();
    n_cmp++;
    if ({bus.dp_wen, bus.dp_waddr, bus.dp_wdata, flags_q} !== {1'b1, 3'd1, 8'h14, 3'b000}) begin
      n_err++;
      $display("FAIL same_reg_wb: wen=%b waddr=%0d wdata=%h flags=%b required 1 1 14 000",
               bus.dp_wen, bus.dp_waddr, bus.dp_wdata, flags_q);
    end
    step();
    n_cmp++;
    if ({rf[1], retired_cnt} !== {8'h14, 8'd6}) begin
      n_err++;
      $display("FAIL same_reg_done: r1=%h cnt=%0d required 14 6", rf[1], retired_cnt);
    end
  endtask

  task automatic test_reset_during_wb();
    issue(16'h0755);  // LDI R7, 0x55 -> now in WB
    rst = 1'b1;
    step();
    n_cmp++;
    if ({bus.dp_wen, bus.instr_ready, retired_cnt, flags_q, rf[7]} !== {1'b0, 1'b0, 8'd0, 3'b000, 8'h00}) begin
      n_err++;
      $display("FAIL rst_in_wb: wen=%b ready=%b cnt=%0d flags=%b r7=%h required 0 0 0 000 00",
               bus.dp_wen, bus.instr_ready, retired_cnt, flags_q, rf[7]);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({bus.instr_ready, bus.dp_wen} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_in_wb_idle: ready=%b wen=%b required 1 0", bus.instr_ready, bus.dp_wen);
    end
  endtask

  task automatic test_back_to_back();
    bus.instr       = 16'h8000;
    bus.instr_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++;
      if ({bus.instr_ready, retired_cnt} !== {1'b1, 8'(i)}) begin
        n_err++;
        $display("FAIL nop_b2b_%0d: ready=%b cnt=%0d required 1 %0d", i, bus.instr_ready, retired_cnt, i);
      end
    end
    bus.instr = 16'hC000;
    step();
    n_cmp++;
    if ({halted, bus.instr_ready, retired_cnt} !== {1'b1, 1'b0, 8'd4}) begin
      n_err++;
      $display("FAIL halt_accept: halted=%b ready=%b cnt=%0d required 1 0 4", halted, bus.instr_ready, retired_cnt);
    end
    bus.instr = 16'h0133;  // ignored while halted
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if ({halted, bus.instr_ready, bus.dp_wen, retired_cnt, rf[1]} !== {1'b1, 1'b0, 1'b0, 8'd4, 8'h00}) begin
      n_err++;
      $display("FAIL halt_ignores: halted=%b ready=%b wen=%b cnt=%0d r1=%h required 1 0 0 4 00",
               halted, bus.instr_ready, bus.dp_wen, retired_cnt, rf[1]);
    end
    bus.instr_valid = 1'b0;
    do_reset();
    n_cmp++;
    if ({halted, bus.instr_ready, retired_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL halt_cleared: halted=%b ready=%b cnt=%0d required 0 1 0", halted, bus.instr_ready, retired_cnt);
    end
  endtask

  task automatic test_wrap();
    bus.instr       = 16'h8000;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 255; i++) step();
    n_cmp++;
    if (retired_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL wrap_255: cnt=%0d required 255", retired_cnt);
    end
    step();
    bus.instr_valid = 1'b0;
    n_cmp++;
    if (retired_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_0: cnt=%0d required 0", retired_cnt);
    end
  endtask

`ifdef DP_SEQ_ILLEGAL_TRAP_EN
  task automatic test_illegal();
    issue(16'h0133);  // LDI R1, 0x33
    step();
    issue(16'h7A24);  // alu_op 111 -> trap
    n_cmp++;
    if ({illegal_q, bus.instr_ready, bus.dp_wen, retired_cnt, flags_q} !== {1'b1, 1'b1, 1'b0, 8'd1, 3'b000}) begin
      n_err++;
      $display("FAIL illegal_trap: illegal=%b ready=%b wen=%b cnt=%0d flags=%b required 1 1 0 1 000",
               illegal_q, bus.instr_ready, bus.dp_wen, retired_cnt, flags_q);
    end
    step();
    step();
    n_cmp++;
    if ({illegal_q, bus.dp_wen, retired_cnt, rf[2]} !== {1'b1, 1'b0, 8'd1, 8'h00}) begin
      n_err++;
      $display("FAIL illegal_nowrite: illegal=%b wen=%b cnt=%0d r2=%h required 1 0 1 00",
               illegal_q, bus.dp_wen, retired_cnt, rf[2]);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    test_reset();
    test_ldi();
    test_alu_add();
    test_cmp();
    test_same_reg();
    test_reset_during_wb();
    test_back_to_back();
    test_wrap();
`ifdef DP_SEQ_ILLEGAL_TRAP_EN
    do_reset();
    test_illegal();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Instruction sequencer directly upstream of datapath_top; owns every datapath control input.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Drives register-file read/write addresses and alu_ctrl, captures alu_result and flags, and writes the result back through wdata/wen.
- Provides single-issue, non-pipelined execution with a sticky flag register and a retire counter.

Parameters:
- DATA_W, 8, datapath word width; the instruction encoding is defined for 8 only.
- ADDR_W, 3, register address width; the instruction encoding is defined for 3 only.
- CNT_W, 8, width of retired_cnt.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept
- instr  in  16  instruction word
- dp_wen  out  1  to datapath wen
- dp_waddr  out  ADDR_W  to datapath waddr
- dp_wdata  out  DATA_W  to datapath wdata
- dp_raddr1  out  ADDR_W  to datapath raddr1
- dp_raddr2  out  ADDR_W  to datapath raddr2
- dp_alu_ctrl  out  3  to datapath alu_ctrl
- dp_alu_result  in  DATA_W  from datapath alu_result (combinational)
- dp_zero, dp_carry, dp_overflow  in  1 each  from datapath
- flags_q  out  3  latched {overflow, carry, zero}
- halted  out  1  HALT executed
- retired_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Encoding: instr[15:14] selects the class.
  - 00 LDI: rd=[10:8], imm=[7:0].
  - 01 ALU: alu_op=[13:11], rd=[10:8], rs1=[7:5], rs2=[4:2], [1]=CMP (flags only, no writeback), [0] ignored.
  - 10 NOP.
  - 11 HALT.
- All outputs are registered. Reset values: every output is 0, state is IDLE.
- instr_ready = 1 only in IDLE. A transfer is instr_valid & instr_ready at a rising edge.
- FSM states: IDLE, EXEC, WB, HALT.
- IDLE, on accept:
  - LDI: dp_waddr<=rd, dp_wdata<=imm, dp_wen<=1, go to WB.
  - ALU: dp_raddr1<=rs1, dp_raddr2<=rs2, dp_alu_ctrl<=alu_op, latch rd and CMP, go to EXEC.
  - NOP: retired_cnt+1, stay in IDLE.
  - HALT: halted<=1, retired_cnt+1, go to HALT.
- EXEC (1 cycle): at the exit edge, flags_q<={dp_overflow, dp_carry, dp_zero}.
  - If CMP=0: dp_wdata<=dp_alu_result, dp_waddr<=rd, dp_wen<=1.
  - If CMP=1: dp_wen stays 0 and retired_cnt+1.
  - Go to WB.
- WB (1 cycle): the datapath writes at the WB exit edge when dp_wen=1. At that edge dp_wen<=0; retired_cnt+1 unless already counted for CMP; go to IDLE.
- HALT: instr_ready=0; remains until rst.
- Latency, accept edge to register written: LDI 2 edges, ALU 3 edges. Throughput: one LDI per 2 cycles, one ALU per 3 cycles, one NOP per cycle.
- dp_raddr1, dp_raddr2 and dp_alu_ctrl hold their last values outside EXEC.
- flags_q changes only at the EXEC exit edge; LDI, NOP and HALT leave it unchanged.
- retired_cnt wraps 2^CNT_W-1 -> 0 with no flag.
- rd equal to rs1 or rs2 is legal: the read happens in EXEC and the write in WB, so there is no hazard.
- rst in any state: IDLE and all outputs 0 on the same edge. A pending write is dropped (dp_wen=0 at the next cycle). rst has priority over an accept.
- instr_valid while not ready: the instruction is ignored, and the upstream must hold it.

Optional Feature:
- Macro: DP_SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - alu_op 3'b110 and 3'b111 are illegal.
  - On accepting an illegal ALU instruction: no EXEC/WB, no write, flags_q unchanged, retired_cnt unchanged.
  - A 1-bit output illegal_q is set sticky; it is cleared only by rst.
  - The sequencer returns to IDLE the next cycle.
- Not defined: no illegal_q port; all alu_op values are passed to the datapath unchanged.

Test Plan:
- Reset, then LDI R1=10, LDI R2=5 -> dp_wen pulses one cycle each with waddr 1/2 and wdata 0x0A/0x05; retired_cnt=2.
- ALU ADD (op 000) rd=3, rs1=1, rs2=2 -> raddr1=1, raddr2=2 in EXEC; WB writes R3=0x0F; flags_q=000; instr_ready low for 2 cycles after accept.
- ALU SUB (op 001) with CMP=1, rs1=2, rs2=2 -> dp_wen never asserted; flags_q zero bit=1; retired_cnt increments.
- instr_valid held high with 3 back-to-back NOPs then HALT -> 4 accepts on consecutive cycles; halted=1; instr_ready stays 0; further instructions ignored until rst.
- Assert rst during WB of an LDI -> dp_wen=0 after that edge, no register write, retired_cnt=0, state IDLE.
- Issue 256 NOPs -> retired_cnt wraps to 0. With DP_SEQ_ILLEGAL_TRAP_EN, alu_op=111 -> illegal_q=1, no write.
